// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback and a buffered
// long-latency result, with starvation forcing and a pending-register scoreboard.
module rf_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_rd_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic              rs1_pending_o,
  output logic              rs2_pending_o,
  output logic              stall_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_ad_o,
  output logic [DATA_W-1:0] rf_wd_o
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic force_grant, wb_ok, buf_grant, accept;

  // Reset masks every write so a buffered result caught by reset is never committed.
  always_comb begin
    force_grant = !rst && buf_valid_q && (wait_cnt_q == LIMIT);
    wb_ok       = !rst && wb_we_i && (wb_rd_i != '0);
    buf_grant   = !rst && buf_valid_q && (force_grant || !wb_ok);
    accept      = lu_valid_i && lu_ready_o;
  end

  always_comb begin
    rf_we_o = 1'b0;
    rf_ad_o = '0;
    rf_wd_o = '0;
    if (buf_grant) begin
      rf_we_o = 1'b1;
      rf_ad_o = buf_rd_q;
      rf_wd_o = buf_data_q;
    end else if (wb_ok) begin
      rf_we_o = 1'b1;
      rf_ad_o = wb_rd_i;
      rf_wd_o = wb_data_i;
    end
  end

  assign stall_o       = force_grant;
  assign lu_ready_o    = !buf_valid_q && !rst;
  assign rs1_pending_o = pending_q[rs1_i];
  assign rs2_pending_o = pending_q[rs2_i];

  // Accept only happens with the buffer empty, so it never collides with a drain.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    wait_cnt_d  = wait_cnt_q;
    if (buf_grant) begin
      buf_valid_d = 1'b0;
      wait_cnt_d  = '0;
    end else if (buf_valid_q && wait_cnt_q != LIMIT) begin
      wait_cnt_d  = wait_cnt_q + 1'b1;
    end
    if (accept && lu_rd_i != '0) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = lu_rd_i;
      buf_data_d  = lu_data_i;
      wait_cnt_d  = '0;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (buf_grant) pending_d[buf_rd_q] = 1'b0;
    if (iss_valid_i && iss_rd_i != '0) pending_d[iss_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      wait_cnt_q  <= '0;
      pending_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
      pending_q   <= pending_d;
    end
  end
endmodule
